// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: hex glyph table,
// segment bit positions and the scan FSM state type.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {g..a} glyphs for nibble values 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SCAN  = 1'b1
  } scanState_t;

endpackage

// File: rtl/hex_seg_dec.sv
// Combinational nibble-to-glyph decoder; blank forces every segment dark.
module hex_seg_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] segs
);

  assign segs = blank ? SEG_OFF[SEG_G:SEG_A] : HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed hex display driver: input latch, per-digit blank/dot,
// leading-zero suppression and an all-dark guard interval between digits.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_CYC  = 100000,
  parameter int GUARD_CYC = 4,
  parameter int IDX_W     = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  le,
  input  logic                  lzs,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [IDX_W-1:0]      scan_idx
);

  localparam int CNT_TOP = ((SCAN_CYC > GUARD_CYC) ? SCAN_CYC : GUARD_CYC) - 1;
  localparam int CNT_W   = (CNT_TOP < 1) ? 1 : $clog2(CNT_TOP + 1);
  localparam logic [DIGITS-1:0] AN_OFF = '1;

  logic [DIGITS-1:0][3:0] dataQ;
  logic [DIGITS-1:0]      dpQ;
  logic [DIGITS-1:0]      blankQ;

  scanState_t             state;
  scanState_t             stateNext;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cntNext;
  logic [IDX_W-1:0]       scanIdx;
  logic [IDX_W-1:0]       idxNext;
  logic [DIGITS-1:0]      anReg;
  logic [DIGITS-1:0]      anNext;
  logic [7:0]             segReg;
  logic [7:0]             segNext;

  logic                   guardDone;
  logic                   scanDone;
  logic [DIGITS:1]        upperZero;
  logic [DIGITS-1:0]      zeroRun;
  logic                   selDark;
  logic [6:0]             litSegs;
  logic [7:0]             litPattern;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataQ  <= '0;
      dpQ    <= '0;
      blankQ <= '0;
    end else if (!le) begin
      dataQ  <= data;
      dpQ    <= dp;
      blankQ <= blank;
    end
  end

  // upperZero[i]: nibbles i..DIGITS-1 are all zero; digit 0 is never suppressed
  assign upperZero[DIGITS] = 1'b1;
  assign zeroRun[0]        = 1'b0;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lzs
    assign upperZero[gi] = (dataQ[gi] == 4'h0) && upperZero[gi+1];
    assign zeroRun[gi]   = lzs && upperZero[gi];
  end

  assign guardDone = (state == ST_GUARD) && (cnt == CNT_W'(GUARD_CYC - 1));
  assign scanDone  = (state == ST_SCAN)  && (cnt == CNT_W'(SCAN_CYC - 1));

  // The pattern is looked up for the index that will be lit after this edge,
  // so a new anode and its glyph leave the output registers together.
  assign idxNext = !guardDone ? scanIdx :
                   (scanIdx == IDX_W'(DIGITS - 1)) ? '0 : scanIdx + 1'b1;

  assign selDark = blankQ[idxNext] | zeroRun[idxNext];

  hex_seg_dec u_dec (
    .nibble (dataQ[idxNext]),
    .blank  (selDark),
    .segs   (litSegs)
  );

  always_comb begin
    litPattern              = SEG_OFF;
    litPattern[SEG_G:SEG_A] = litSegs;
    litPattern[SEG_DP]      = blankQ[idxNext] ? 1'b1 : ~dpQ[idxNext];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_GUARD;
      cnt     <= '0;
      scanIdx <= IDX_W'(DIGITS - 1);
      anReg   <= AN_OFF;
      segReg  <= SEG_OFF;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      scanIdx <= idxNext;
      anReg   <= anNext;
      segReg  <= segNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt + 1'b1;
    anNext    = AN_OFF;
    segNext   = SEG_OFF;
    case (state)
      ST_GUARD: begin
        if (guardDone) begin
          cntNext   = '0;
          stateNext = ST_SCAN;
          anNext    = ~(DIGITS'(1) << idxNext);
          segNext   = litPattern;
        end
      end
      ST_SCAN: begin
        if (scanDone) begin
          cntNext   = '0;
          stateNext = ST_GUARD;
        end else begin
          anNext    = ~(DIGITS'(1) << idxNext);
          segNext   = litPattern;
        end
      end
      default: begin
        cntNext   = '0;
        stateNext = ST_GUARD;
      end
    endcase
  end

  assign seg      = segReg;
  assign an       = anReg;
  assign scan_idx = scanIdx;

endmodule
